cpu_mc: RTL and testbench
=========================

// Module: cpu_mc
// PURPOSE
//  Parametrised multicycle accumulator CPU. Successor to the fixed 6/16-bit core.
//  Adds memory wait states (req/ack) and ready/valid IN/OUT handshakes.
//  Adds JMP, BEQ and MOV-immediate, plus an explicit halted flag.
//  Sits between the top-level memory and the board I/O (switches in, 7-seg out).
// PARAMETERS
//  ADDR_WIDTH  6   memory address width; pc and sp width
//  DATA_WIDTH  16  word width; must be >= 16
//  START_PC    8   pc value after reset
//  SP_INIT     2**ADDR_WIDTH-1  sp value after reset
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous, active-high reset
//  mem_req    out  1   memory access request; addr/we/wdata held stable while high
//  mem_we     out  1   1 = write, 0 = read; valid only with mem_req
//  mem_addr   out  AW  access address
//  mem_wdata  out  DW  write data
//  mem_rdata  in   DW  read data; valid in the cycle mem_ack=1
//  mem_ack    in   1   completes the pending access; may be high in the mem_req cycle
//  in_data    in   DW  input word
//  in_valid   in   1   in_data valid
//  in_ready   out  1   CPU accepts in_data (transfer when in_valid & in_ready)
//  out_data   out  DW  output word; held until the next OUT transfer
//  out_valid  out  1   out_data offered (transfer when out_valid & out_ready)
//  out_ready  in   1   sink accepts out_data
//  pc, sp     out  AW  architectural registers (debug)
//  state      out  5   current FSM state encoding (debug)
//  halted     out  1   STOP executed
// BEHAVIOUR
//  Reset: pc=START_PC, sp=SP_INIT, acc=0, ir=0, state=FETCH.
//   mem_req=0, in_ready=0, out_valid=0, out_data=0, halted=0.
//   A rst pulse mid-access drops mem_req next cycle; the pending access is abandoned.
//  Instruction word: op=[DW-1:DW-4]; operands X=[11:8], Y=[7:4], Z=[3:0].
//   Each operand field is {ind, addr[2:0]}.
//   ind=0: value is mem[addr].
//   ind=1: mem[addr] holds the effective address; it costs one extra read.
//  Opcodes:
//   MOV=0: X<=Y. If Z==4'b1000, X<=next word (immediate).
//   ADD=1, SUB=2, MUL=3, DIV=4: X<=Y op Z.
//   IN=7: X<=in_data.  OUT=8: out<=X.
//   JMP=9: pc<=next word.
//   BEQ=A: if X==Y then pc<=next word, else pc<=pc+1 (skip the target word).
//   STOP=F: halt.
//   Any other opcode is a NOP.
//  Arithmetic: unsigned, truncated to DW. SUB wraps modulo 2**DW. MUL keeps the low DW bits.
//   DIV is floor division; DIV by 0 yields 0. Never traps.
//  Memory access: every read/write is one MEM micro-step.
//   Drive mem_req=1 with addr/we/wdata and hold them until the cycle mem_ack=1.
//   Read data is captured on that edge; the FSM advances on the ack.
//   Zero-wait memory (ack tied high) costs 1 cycle per access.
//   mem_ack while mem_req=0 is ignored.
//  FSM states:
//   FETCH  -> DECODE   read mem[pc]; pc++ on ack
//   DECODE -> IMM      for MOV-imm/JMP/BEQ: read mem[pc]; pc++ on ack
//   DECODE -> OPY      otherwise
//   OPY    -> OPZ      read Y (+ind step); result into acc
//   OPZ    -> EXEC     read Z (+ind step)
//   EXEC   -> WB       alu(acc, Z) into acc
//   WB     -> FETCH    resolve X address (+ind step), then write acc
//   IN_WAIT -> WB      in_ready=1 until in_valid. Capture in_data into acc on the transfer edge.
//                      in_ready falls the cycle after. Resolve X and write in WB.
//   OUT_WAIT -> FETCH  first read X into out_data, then assert out_valid.
//                      Hold until out_ready; out_valid drops the cycle after the transfer.
//   HALT               halted=1, no mem_req, stays until rst.
//  States an opcode does not need are skipped.
//   MOV: Y -> acc -> WB.  JMP: no operand reads.  BEQ: read X and Y, compare, no write.
//  pc wraps modulo 2**AW. sp is held at SP_INIT; it is reserved for a later CALL/RET.
//  in_valid and out_ready are sampled only in their wait states. No combinational in->out paths.
// STRUCTURE
//  Package cpu_mc_pkg: opcode localparams, FSM state encoding, IMM_TAG=4'b1000.
//  Sub-module cpu_mc_alu: combinational, op + DW-bit a/b -> f; includes the DIV-by-0 rule.
//  Reuse the shared register block for pc, sp, ir, acc and the effective-address temp.
// TESTING
//  1. Reset: rst high 2 cycles -> pc=8, sp=63, mem_req=0, out_valid=0, halted=0.
//  2. ADD: mem[1]=5, mem[2]=7, "ADD 0,1,2" at 8, zero-wait memory.
//     -> mem[0]=12, next fetch at pc=9.
//  3. Indirect + wait states: mem_ack delayed 3 cycles, mem[3]=20, mem[20]=9, mem[2]=0.
//     "MOV 4,(3)" -> mem[4]=9. Addr/we stay stable during every wait.
//  4. IN: in_valid low for 5 cycles, then in_data=0x00AB.
//     -> in_ready held high throughout; mem[1]=0x00AB after a single transfer.
//  5. OUT backpressure: mem[2]=0x1234, out_ready low for 4 cycles.
//     -> out_data=0x1234 and out_valid stable until the handshake; FSM resumes at FETCH.
//  6. Control flow: BEQ 1,2 with mem[1]=mem[2]=3 and target 20 -> pc=20.
//     DIV 0,1,2 with mem[2]=0 -> mem[0]=0. STOP -> halted=1, no further mem_req.

Source files
------------

// File: rtl/cpu_mc_pkg.sv
// ---------------------------------------------------------------
// cpu_mc_pkg: opcodes, FSM encoding and helpers for cpu_mc. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package cpu_mc_pkg;

  localparam logic [3:0] OP_MOV  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_DIV  = 4'h4;
  localparam logic [3:0] OP_IN   = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_STOP = 4'hF;

  localparam logic [3:0] IMM_TAG = 4'b1000;

  typedef enum logic [4:0] {
    ST_FETCH    = 5'd0,
    ST_DECODE   = 5'd1,
    ST_IMM      = 5'd2,
    ST_OPX      = 5'd3,
    ST_OPY      = 5'd4,
    ST_OPZ      = 5'd5,
    ST_EXEC     = 5'd6,
    ST_WB       = 5'd7,
    ST_IN_WAIT  = 5'd8,
    ST_OUT_WAIT = 5'd9,
    ST_HALT     = 5'd10
  } state_e;

  function automatic logic needs_mem(input state_e s);
    return s inside {ST_FETCH, ST_IMM, ST_OPX, ST_OPY, ST_OPZ, ST_WB};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_mc_alu.sv
// ---------------------------------------------------------------
// cpu_mc_alu: unsigned DW-bit ALU, DIV by zero yields zero. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module cpu_mc_alu
  import cpu_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] f
);

  always_comb begin
    f = a;
    case (op)
      OP_ADD:  f = a + b;
      OP_SUB:  f = a - b;
      OP_MUL:  f = a * b;
      OP_DIV:  f = (b == '0) ? '0 : a / b;
      default: f = a;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cpu_mc.sv
// ---------------------------------------------------------------
// cpu_mc: multicycle accumulator CPU with req/ack memory and I/O. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] START_PC   = ADDR_WIDTH'(8),
  parameter logic [ADDR_WIDTH-1:0] SP_INIT    = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] sp,
  output logic [4:0]            state,
  output logic                  halted
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d, sp_q, sp_d, ea_q, ea_d;
  logic [DATA_WIDTH-1:0]   ir_q, ir_d, acc_q, acc_d, tmp_q, tmp_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d, alu_f;
  logic                    ind_q, ind_d, req_q, req_d;
  logic                    ack, ptr_step;
  logic [3:0]              op, fld;

  assign op  = ir_q[DATA_WIDTH-1:DATA_WIDTH-4];
  assign ack = req_q & mem_ack;

  always_comb begin
    fld = ir_q[3:0];
    case (state_q)
      ST_OPX, ST_WB: fld = ir_q[11:8];
      ST_OPY:        fld = ir_q[7:4];
      default:       fld = ir_q[3:0];
    endcase
  end

  // Indirect operand: first access fetches the pointer into ea_q, second uses it.
  assign ptr_step  = fld[3] & ~ind_q;
  assign mem_req   = req_q;
  assign mem_we    = (state_q == ST_WB) & ~ptr_step;
  assign mem_wdata = acc_q;
  assign mem_addr  = (state_q == ST_FETCH || state_q == ST_IMM) ? pc_q :
                     ind_q ? ea_q : {{(ADDR_WIDTH-3){1'b0}}, fld[2:0]};

  cpu_mc_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op (op),
    .a  (acc_q),
    .b  (tmp_q),
    .f  (alu_f)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    sp_d       = sp_q;
    ir_d       = ir_q;
    acc_d      = acc_q;
    tmp_d      = tmp_q;
    ea_d       = ea_q;
    ind_d      = ind_q;
    out_data_d = out_data_q;
    case (state_q)
      ST_FETCH: if (ack) begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (op)
          OP_MOV:                         state_d = (ir_q[3:0] == IMM_TAG) ? ST_IMM : ST_OPY;
          OP_ADD, OP_SUB, OP_MUL, OP_DIV: state_d = ST_OPY;
          OP_IN:                          state_d = ST_IN_WAIT;
          OP_OUT:                         state_d = ST_OPX;
          OP_JMP, OP_BEQ:                 state_d = ST_IMM;
          OP_STOP:                        state_d = ST_HALT;
          default:                        state_d = ST_FETCH;
        endcase
      end
      ST_IMM: if (ack) begin
        pc_d = pc_q + 1'b1;
        case (op)
          OP_JMP: begin pc_d = mem_rdata[ADDR_WIDTH-1:0]; state_d = ST_FETCH; end
          OP_BEQ: begin tmp_d = mem_rdata; state_d = ST_OPX; end
          default: begin acc_d = mem_rdata; state_d = ST_WB; end
        endcase
      end
      ST_OPX, ST_OPY, ST_OPZ, ST_WB: if (ack) begin
        if (ptr_step) begin
          ea_d  = mem_rdata[ADDR_WIDTH-1:0];
          ind_d = 1'b1;
        end else begin
          ind_d = 1'b0;
          case (state_q)
            ST_OPX: begin
              if (op == OP_OUT) begin
                out_data_d = mem_rdata;
                state_d    = ST_OUT_WAIT;
              end else begin
                acc_d   = mem_rdata;
                state_d = ST_OPY;
              end
            end
            ST_OPY: begin
              if (op == OP_BEQ) begin
                if (mem_rdata == acc_q) pc_d = tmp_q[ADDR_WIDTH-1:0];
                state_d = ST_FETCH;
              end else begin
                acc_d   = mem_rdata;
                state_d = (op == OP_MOV) ? ST_WB : ST_OPZ;
              end
            end
            ST_OPZ: begin
              tmp_d   = mem_rdata;
              state_d = ST_EXEC;
            end
            default: state_d = ST_FETCH;
          endcase
        end
      end
      ST_EXEC: begin
        acc_d   = alu_f;
        state_d = ST_WB;
      end
      ST_IN_WAIT: if (in_valid) begin
        acc_d   = in_data;
        state_d = ST_WB;
      end
      ST_OUT_WAIT: if (out_ready) state_d = ST_FETCH;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_FETCH;
    endcase
    // Request is registered from the next state so it is low for one cycle after reset.
    req_d = needs_mem(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= START_PC;
      sp_q       <= SP_INIT;
      ir_q       <= '0;
      acc_q      <= '0;
      tmp_q      <= '0;
      ea_q       <= '0;
      ind_q      <= 1'b0;
      req_q      <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      ir_q       <= ir_d;
      acc_q      <= acc_d;
      tmp_q      <= tmp_d;
      ea_q       <= ea_d;
      ind_q      <= ind_d;
      req_q      <= req_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == ST_IN_WAIT);
  assign out_valid = (state_q == ST_OUT_WAIT);
  assign halted    = (state_q == ST_HALT);
  assign out_data  = out_data_q;
  assign pc        = pc_q;
  assign sp        = sp_q;
  assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_mc.sv
// ---------------------------------------------------------------
// tb_cpu_mc: directed self-checking bench for cpu_mc. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_cpu_mc;
  import cpu_mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ack;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] in_data = 16'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  pc, sp;
  logic [4:0]  state;
  logic        halted;

  logic [15:0] mem [64];
  logic [15:0] img [64];
  logic        load = 1'b0;
  int          ack_delay = 0;
  int          wcnt = 0;

  int checks = 0;
  int errors = 0;
  int stab_err = 0;
  int in_xfer = 0;
  int halt_req = 0;
  logic       prev_busy = 1'b0;
  logic [5:0] prev_addr = '0;
  logic       prev_we = 1'b0;

  always #5 clk = ~clk;

  cpu_mc dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pc        (pc),
    .sp        (sp),
    .state     (state),
    .halted    (halted)
  );

  // Memory responder: ack after ack_delay wait cycles, combinational read data.
  assign mem_ack   = mem_req && (wcnt >= ack_delay);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (load) mem <= img;
    else if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
    wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
  end

  always @(posedge clk) begin
    if (prev_busy && mem_req && (mem_addr !== prev_addr || mem_we !== prev_we)) stab_err = stab_err + 1;
    if (in_valid && in_ready) in_xfer = in_xfer + 1;
    if (halted && mem_req) halt_req = halt_req + 1;
    prev_busy <= mem_req && !mem_ack && !rst;
    prev_addr <= mem_addr;
    prev_we   <= mem_we;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = 16'h0;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!halted && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    int n;
    logic ok;

    // Reset values, then a reset pulse in the middle of a waited access.
    clear_img();
    ack_delay = 3;
    load = 1'b1;
    repeat (2) @(negedge clk);
    load = 1'b0;
    chk("rst_pc", {26'd0, pc}, 32'd8);
    chk("rst_sp", {26'd0, sp}, 32'd63);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_outv", {31'd0, out_valid}, 32'd0);
    chk("rst_halt", {31'd0, halted}, 32'd0);
    chk("rst_inrdy", {31'd0, in_ready}, 32'd0);
    chk("rst_outd", {16'd0, out_data}, 32'd0);
    chk("rst_state", {27'd0, state}, {27'd0, ST_FETCH});
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midacc_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midacc_drop", {31'd0, mem_req}, 32'd0);

    // ADD 0,1,2 on zero-wait memory.
    clear_img();
    img[1] = 16'd5; img[2] = 16'd7;
    img[8] = 16'h1012; img[9] = 16'hF000;
    ack_delay = 0;
    do_reset();
    n = 0;
    while (!(mem_req && mem_ack && mem_we) && n < 100) begin @(negedge clk); n++; end
    chk("add_wr_seen", {31'd0, mem_req && mem_ack && mem_we}, 32'd1);
    @(negedge clk);
    chk("add_mem0", {16'd0, mem[0]}, 32'd12);
    chk("add_pc", {26'd0, pc}, 32'd9);
    chk("add_state", {27'd0, state}, {27'd0, ST_FETCH});
    wait_halt("add_halt");

    // MOV 4,(3) with three wait states per access.
    clear_img();
    img[2] = 16'd0; img[3] = 16'd20; img[20] = 16'd9;
    img[8] = 16'h04B0; img[9] = 16'hF000;
    ack_delay = 3;
    do_reset();
    wait_halt("ind_halt");
    chk("ind_mem4", {16'd0, mem[4]}, 32'd9);
    chk("ind_stable", stab_err, 32'd0);

    // IN 1 with a late producer.
    clear_img();
    img[8] = 16'h7100; img[9] = 16'hF000;
    ack_delay = 1;
    do_reset();
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("in_rdy_up", {31'd0, in_ready}, 32'd1);
    ok = 1'b1;
    repeat (5) begin @(negedge clk); ok = ok & in_ready; end
    chk("in_rdy_hold", {31'd0, ok}, 32'd1);
    in_data = 16'h00AB; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_data = 16'h0;
    chk("in_rdy_drop", {31'd0, in_ready}, 32'd0);
    wait_halt("in_halt");
    chk("in_mem1", {16'd0, mem[1]}, 32'h00AB);
    chk("in_xfers", in_xfer, 32'd1);

    // OUT 2 with a stalled sink.
    clear_img();
    img[2] = 16'h1234;
    img[8] = 16'h8200; img[9] = 16'hF000;
    ack_delay = 0;
    do_reset();
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("out_valid_up", {31'd0, out_valid}, 32'd1);
    chk("out_data", {16'd0, out_data}, 32'h1234);
    ok = 1'b1;
    repeat (4) begin @(negedge clk); ok = ok & out_valid & (out_data == 16'h1234); end
    chk("out_hold", {31'd0, ok}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("out_state", {27'd0, state}, {27'd0, ST_FETCH});
    chk("out_data_held", {16'd0, out_data}, 32'h1234);
    wait_halt("out_halt");

    // BEQ taken, MOV-imm, DIV by zero, STOP.
    clear_img();
    img[0] = 16'hFFFF; img[1] = 16'd3; img[2] = 16'd3; img[5] = 16'h1111;
    img[8] = 16'hA120; img[9] = 16'd20; img[10] = 16'h0508; img[11] = 16'h0BAD; img[12] = 16'hF000;
    img[20] = 16'h0208; img[21] = 16'h0000; img[22] = 16'h4012; img[23] = 16'hF000;
    ack_delay = 0;
    do_reset();
    n = 0;
    while (!(state == ST_FETCH && pc == 6'd20) && n < 60) begin @(negedge clk); n++; end
    chk("beq_taken_pc", {26'd0, pc}, 32'd20);
    wait_halt("beq_halt");
    chk("div0_mem0", {16'd0, mem[0]}, 32'd0);
    chk("movi_mem2", {16'd0, mem[2]}, 32'd0);
    chk("beq_skip_mem5", {16'd0, mem[5]}, 32'h1111);
    repeat (5) @(negedge clk);
    chk("halt_state", {27'd0, state}, {27'd0, ST_HALT});
    chk("halt_noreq", halt_req, 32'd0);

    // BEQ not taken: falls through past the target word.
    img[2] = 16'd4;
    do_reset();
    wait_halt("bne_halt");
    chk("bne_mem5", {16'd0, mem[5]}, 32'h0BAD);
    chk("bne_pc", {26'd0, pc}, 32'd13);

    // JMP then SUB wrap, MUL truncation, DIV.
    clear_img();
    img[1] = 16'd100; img[2] = 16'd101; img[4] = 16'h0100; img[5] = 16'h0101; img[7] = 16'd7;
    img[8] = 16'h9000; img[9] = 16'd30;
    img[30] = 16'h2012; img[31] = 16'h3345; img[32] = 16'h4617; img[33] = 16'hF000;
    ack_delay = 2;
    do_reset();
    wait_halt("alu_halt");
    chk("sub_wrap", {16'd0, mem[0]}, 32'hFFFF);
    chk("mul_trunc", {16'd0, mem[3]}, 32'h0100);
    chk("div_floor", {16'd0, mem[6]}, 32'd14);
    chk("jmp_pc", {26'd0, pc}, 32'd34);
    chk("sp_held", {26'd0, sp}, 32'd63);
    chk("all_stable", stab_err, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
